// File: rtl/imem_fill_responder_if.sv
// Bundle of signals for the instruction-cache line-fill responder: request
// handshake, per-word response stream, RAM read port and the busy flag.
interface imem_fill_responder_if #(
  parameter int RAM_AW = 14
) ();
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              flush;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [31:0]       resp_addr;
  logic              resp_last;
  logic              ram_en;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic              busy;

  modport master (
    output req_valid, req_addr, flush, ram_data,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_last,
           ram_en, ram_addr, busy
  );

  modport slave (
    input  req_valid, req_addr, flush, ram_data,
    output req_ready, resp_valid, resp_data, resp_addr, resp_last,
           ram_en, ram_addr, busy
  );
endinterface

// File: rtl/imem_fill_responder.sv
// Serves one I-cache line fill at a time from a synchronous RAM, returning the
// line critical-word-first with wrap-around; a flush abandons the fill.
module imem_fill_responder #(
  parameter int LINE_WORDS = 4,
  parameter int RAM_AW     = 14
) (
  input logic                  clk,
  input logic                  rst,
  imem_fill_responder_if.slave bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam logic [OW-1:0] LAST_N = OW'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31-OW-2:0]  line_q, line_d;
  logic [OW-1:0]     idx_q, idx_d;
  logic [OW-1:0]     n_q, n_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              pipe_en_q, pipe_en_d;
  logic              pipe_last_q, pipe_last_d;
  logic [31:0]       pipe_addr_q, pipe_addr_d;

  logic              accept_s;
  logic              issue_s;
  logic [31:0]       issue_byte_s;
  logic [RAM_AW-1:0] issue_word_s;

  // The line base has zero offset bits, so base/4 + idx is a plain concatenation.
  assign issue_byte_s = {line_q, idx_q, 2'b00};
  assign issue_word_s = issue_byte_s[RAM_AW+1:2];
  assign issue_s      = (state_q == S_ISSUE) && !bus.flush;
  assign accept_s     = bus.req_valid && bus.req_ready;

  // Outputs are forced to their reset values in any cycle with rst high.
  assign bus.req_ready  = !rst && !bus.flush && ((state_q == S_IDLE) || (state_q == S_DRAIN));
  assign bus.ram_en     = !rst && issue_s;
  assign bus.ram_addr   = rst ? {RAM_AW{1'b0}} : (issue_s ? issue_word_s : ram_addr_q);
  assign bus.resp_valid = !rst && !bus.flush && pipe_en_q;
  assign bus.resp_data  = bus.resp_valid ? bus.ram_data : 32'h0000_0000;
  assign bus.resp_addr  = rst ? 32'h0000_0000 : pipe_addr_q;
  assign bus.resp_last  = bus.resp_valid && pipe_last_q;
  assign bus.busy       = !rst && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  // Next-state logic for the fill sequencer and the response pipeline register.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    idx_d       = idx_q;
    n_d         = n_q;
    ram_addr_d  = ram_addr_q;
    pipe_en_d   = 1'b0;
    pipe_last_d = 1'b0;
    pipe_addr_d = pipe_addr_q;
    if (bus.flush) begin
      state_d     = S_IDLE;
      pipe_addr_d = 32'h0000_0000;
    end else begin
      case (state_q)
        S_ISSUE: begin
          pipe_en_d   = 1'b1;
          pipe_last_d = (n_q == LAST_N);
          pipe_addr_d = issue_byte_s;
          ram_addr_d  = issue_word_s;
          idx_d       = idx_q + {{(OW-1){1'b0}}, 1'b1};
          n_d         = n_q + {{(OW-1){1'b0}}, 1'b1};
          state_d     = (n_q == LAST_N) ? S_DRAIN : S_ISSUE;
        end
        S_IDLE, S_DRAIN: begin
          if (accept_s) begin
            line_d  = bus.req_addr[31:OW+2];
            idx_d   = bus.req_addr[OW+1:2];
            n_d     = {OW{1'b0}};
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and pipeline flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      idx_q       <= {OW{1'b0}};
      n_q         <= {OW{1'b0}};
      ram_addr_q  <= {RAM_AW{1'b0}};
      pipe_en_q   <= 1'b0;
      pipe_last_q <= 1'b0;
      pipe_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      ram_addr_q  <= ram_addr_d;
      pipe_en_q   <= pipe_en_d;
      pipe_last_q <= pipe_last_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end
endmodule

// File: tb/tb_imem_fill_responder.sv
// Bench for imem_fill_responder: directed vector table, hand-written corner
// sequences, then random traffic checked against a per-cycle schedule model.
module tb_imem_fill_responder;
  localparam int LW = 4;
  localparam int AW = 14;
  localparam int NC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fill_responder_if #(.RAM_AW(AW)) bus ();

  imem_fill_responder #(.LINE_WORDS(LW), .RAM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a, 2'b01, ~a, 2'b10};
  endfunction

  function automatic logic [AW-1:0] wa(input logic [31:0] b);
    return b[AW+1:2];
  endfunction

  // Synchronous RAM: data appears the cycle after the read enable.
  logic [31:0] ram_q = 32'h0;
  always @(posedge clk) if (bus.ram_en) ram_q <= mem_word(bus.ram_addr);
  assign bus.ram_data = ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference schedule: what must be issued / returned in each cycle.
  bit          iss_v   [NC];
  logic [31:0] iss_byte[NC];
  bit          rsp_v   [NC];
  logic [31:0] rsp_byte[NC];
  bit          rsp_lst [NC];
  logic [AW-1:0] last_ra = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] a, input bit f);
    bit e_ready, e_en, e_rv, e_last, e_busy;
    logic [AW-1:0] e_ra;
    logic [31:0] base, e_data;
    int start, j;
    @(negedge clk);
    rst = r; bus.req_valid = v; bus.req_addr = a; bus.flush = f;
    #1;
    e_ready = !r && !f && !iss_v[cyc];
    e_en    = !r && !f && iss_v[cyc];
    e_ra    = r ? '0 : (e_en ? wa(iss_byte[cyc]) : last_ra);
    e_rv    = !r && !f && rsp_v[cyc];
    e_last  = e_rv && rsp_lst[cyc];
    e_busy  = !r && (iss_v[cyc] || rsp_v[cyc]);
    e_data  = e_rv ? mem_word(wa(rsp_byte[cyc])) : 32'h0;
    chk("req_ready",  32'(bus.req_ready),  32'(e_ready));
    chk("ram_en",     32'(bus.ram_en),     32'(e_en));
    chk("ram_addr",   32'(bus.ram_addr),   32'(e_ra));
    chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    chk("resp_last",  32'(bus.resp_last),  32'(e_last));
    chk("busy",       32'(bus.busy),       32'(e_busy));
    chk("resp_data",  bus.resp_data,       e_data);
    if (r) chk("resp_addr_rst", bus.resp_addr, 32'h0);
    if (e_rv) chk("resp_addr", bus.resp_addr, rsp_byte[cyc]);
    if (r) last_ra = '0;
    else if (e_en) last_ra = wa(iss_byte[cyc]);
    if (r || f) begin
      for (int i = cyc + 1; i < cyc + LW + 3; i++) begin
        iss_v[i] = 1'b0;
        rsp_v[i] = 1'b0;
      end
    end
    if (v && e_ready) begin
      base  = a & ~32'(LW * 4 - 1);
      start = int'((a >> 2) % LW);
      for (int k = 0; k < LW; k++) begin
        j = cyc + 1 + k;
        iss_v[j]      = 1'b1;
        iss_byte[j]   = base + 32'(((start + k) % LW) * 4);
        rsp_v[j+1]    = 1'b1;
        rsp_byte[j+1] = iss_byte[j];
        rsp_lst[j+1]  = (k == LW - 1);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] addr;
    bit          fl;
    bit          e_ready;
    bit          e_en;
    logic [13:0] e_ra;
    bit          e_rv;
    logic [31:0] e_raddr;
    bit          e_last;
    bit          e_busy;
  } vec_t;

  vec_t tbl[$];
  int   rv_seen;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;

    // Reset, aligned fill 0x1000, wrapped fill 0x1008, flush blocking an IDLE request.
    tbl.push_back('{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 14'h000, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 14'h000, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 14'h000, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h400, 1'b0, 32'h0,    1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h401, 1'b1, 32'h1000, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h402, 1'b1, 32'h1004, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h403, 1'b1, 32'h1008, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 14'h403, 1'b1, 32'h100C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h1008, 1'b0, 1'b1, 1'b0, 14'h403, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h402, 1'b0, 32'h0,    1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h403, 1'b1, 32'h1008, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h400, 1'b1, 32'h100C, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'h401, 1'b1, 32'h1000, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 14'h401, 1'b1, 32'h1004, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 14'h401, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 14'h401, 1'b0, 32'h0,    1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'hC00, 1'b0, 32'h0,    1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 14'hC01, 1'b1, 32'h3000, 1'b0, 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].addr, tbl[i].fl);
      chk("tbl_req_ready",  32'(bus.req_ready),  32'(tbl[i].e_ready));
      chk("tbl_ram_en",     32'(bus.ram_en),     32'(tbl[i].e_en));
      chk("tbl_ram_addr",   32'(bus.ram_addr),   32'(tbl[i].e_ra));
      chk("tbl_resp_valid", 32'(bus.resp_valid), 32'(tbl[i].e_rv));
      chk("tbl_resp_last",  32'(bus.resp_last),  32'(tbl[i].e_last));
      chk("tbl_busy",       32'(bus.busy),       32'(tbl[i].e_busy));
      if (tbl[i].e_rv || tbl[i].rst) chk("tbl_resp_addr", bus.resp_addr, tbl[i].e_raddr);
      chk("tbl_resp_data", bus.resp_data,
          tbl[i].e_rv ? mem_word(wa(tbl[i].e_raddr)) : 32'h0);
    end
    idle(6);

    // Back-to-back: second request held until it is taken in DRAIN.
    step(1'b0, 1'b1, 32'h1000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h2004, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("b2b_first_issue", 32'(bus.ram_addr), 32'h801);
    chk("b2b_first_en", 32'(bus.ram_en), 32'h1);
    idle(6);

    // Flush on the second response cycle, then a clean fill.
    step(1'b0, 1'b1, 32'h4008, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_masked", 32'(bus.resp_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_busy", 32'(bus.busy), 32'h0);
    chk("flush_ready", 32'(bus.req_ready), 32'h1);
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus.resp_valid) rv_seen++;
    end
    chk("flush_no_resp", 32'(rv_seen), 32'h0);
    step(1'b0, 1'b1, 32'h5000, 1'b0);
    idle(7);

    // Reset mid-ISSUE.
    step(1'b0, 1'b1, 32'h6004, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus.resp_valid) rv_seen++;
    end
    chk("rst_no_resp", 32'(rv_seen), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);

    // Random traffic against the schedule model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0), 1'($urandom_range(1)), $urandom,
           ($urandom_range(14) == 0));
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
